// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with 2-flop input synchronizer and mid-bit sampling.
// Optional even-parity checking is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       iClk,
    input  logic       iReset,
    input  logic       iRx,
    output logic [7:0] ovData,
    output logic       oValid,
    output logic       oFrameError,
`ifdef UART_RX_PARITY_EN
    output logic       oParityError,
`endif
    output logic       oBusy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bitIdx;
    logic [7:0]    shiftReg;
    logic          rxMeta;
    logic          rxS;
`ifdef UART_RX_PARITY_EN
    logic          parBit;
`endif

    always_ff @(posedge iClk) begin
        if (iReset) begin
            rxMeta      <= 1'b1;
            rxS         <= 1'b1;
            state       <= IDLE;
            cnt         <= '0;
            bitIdx      <= '0;
            shiftReg    <= '0;
            ovData      <= '0;
            oValid      <= 1'b0;
            oFrameError <= 1'b0;
            oBusy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parBit       <= 1'b0;
            oParityError <= 1'b0;
`endif
        end else begin
            rxMeta      <= iRx;
            rxS         <= rxMeta;
            oValid      <= 1'b0;
            oFrameError <= 1'b0;
`ifdef UART_RX_PARITY_EN
            oParityError <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!rxS) begin
                        state <= START;
                        cnt   <= '0;
                        oBusy <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rxS) begin
                            state  <= DATA;
                            bitIdx <= '0;
                        end else begin
                            state <= IDLE;
                            oBusy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt      <= '0;
                        shiftReg <= {rxS, shiftReg[7:1]};
                        bitIdx   <= bitIdx + 3'd1;
                        if (bitIdx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == BIT_LAST) begin
                        cnt    <= '0;
                        parBit <= rxS;
                        state  <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    // Leave at mid-stop-bit so a back-to-back start edge is not missed.
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rxS) begin
                            state <= IDLE;
                            oBusy <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            if (^{shiftReg, parBit}) begin
                                oParityError <= 1'b1;
                            end else begin
                                ovData <= shiftReg;
                                oValid <= 1'b1;
                            end
`else
                            ovData <= shiftReg;
                            oValid <= 1'b1;
`endif
                        end else begin
                            state       <= BREAK;
                            oFrameError <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: begin
                    // A held-low line must go high before a new start bit is accepted.
                    if (rxS) begin
                        state <= IDLE;
                        cnt   <= '0;
                        oBusy <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    oBusy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 16 clocks/bit: frame table plus corner sequences.
module tb_uart_rx_byte;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_EXTRA = CPB;
`else
    localparam int PAR_EXTRA = 0;
`endif

    logic       iClk = 1'b0;
    logic       iReset = 1'b1;
    logic       iRx = 1'b1;
    logic [7:0] ovData;
    logic       oValid;
    logic       oFrameError;
    logic       oBusy;
`ifdef UART_RX_PARITY_EN
    logic       oParityError;
`endif

    uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
        .iClk(iClk),
        .iReset(iReset),
        .iRx(iRx),
        .ovData(ovData),
        .oValid(oValid),
        .oFrameError(oFrameError),
`ifdef UART_RX_PARITY_EN
        .oParityError(oParityError),
`endif
        .oBusy(oBusy)
    );

    always #5 iClk = ~iClk;

    int cyc = 0;
    int nValid = 0;
    int nFerr = 0;
    int nPerr = 0;
    int validCyc = 0;
    int startCyc = 0;
    int errors = 0;
    int checks = 0;

    always @(posedge iClk) cyc <= cyc + 1;

    always @(negedge iClk) begin
        if (oValid) begin
            nValid   = nValid + 1;
            validCyc = cyc;
        end
        if (oFrameError) nFerr = nFerr + 1;
`ifdef UART_RX_PARITY_EN
        if (oParityError) nPerr = nPerr + 1;
`endif
        if (oValid || oFrameError) begin
            checks = checks + 1;
            if (oValid && oFrameError) begin
                errors = errors + 1;
                $display("FAIL strobe_exclusive: oValid=%0b oFrameError=%0b at cycle %0d, required not both",
                         oValid, oFrameError, cyc);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        iRx = 1'b1;
        repeat (n) @(negedge iClk);
    endtask

    // Drives one frame from a negedge; returns at the negedge ending the stop bit.
    task automatic sendFrame(input logic [7:0] d, input logic parFlip, input logic stopBit);
        iRx = 1'b0;
        startCyc = cyc;
        repeat (CPB) @(negedge iClk);
        for (int b = 0; b < 8; b++) begin
            iRx = d[b];
            repeat (CPB) @(negedge iClk);
        end
`ifdef UART_RX_PARITY_EN
        iRx = (^d) ^ parFlip;
        repeat (CPB) @(negedge iClk);
`else
        if (parFlip) $display("note: parity flip ignored without parity build");
`endif
        iRx = stopBit;
        repeat (CPB) @(negedge iClk);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stopBit;
        int         holdLow;
        int         idleAfter;
        int         expValid;
        int         expFerr;
        logic [7:0] expData;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int v0, f0, p0, lat;
        vecs[0] = '{8'h41, 1'b1, 0,   20, 1, 0, 8'h41};
        vecs[1] = '{8'h5A, 1'b1, 0,   0,  1, 0, 8'h5A};
        vecs[2] = '{8'h48, 1'b1, 0,   20, 1, 0, 8'h48};
        vecs[3] = '{8'h43, 1'b0, 100, 4,  0, 1, 8'h48};
        vecs[4] = '{8'h44, 1'b1, 0,   10, 1, 0, 8'h44};
        vecs[5] = '{8'h00, 1'b1, 0,   10, 1, 0, 8'h00};
        vecs[6] = '{8'hFF, 1'b1, 0,   10, 1, 0, 8'hFF};

        repeat (4) @(negedge iClk);
        iReset = 1'b0;
        idle(200);
        check("reset_oValid", int'(oValid), 0);
        check("reset_oFrameError", int'(oFrameError), 0);
        check("reset_oBusy", int'(oBusy), 0);
        check("reset_ovData", int'(ovData), 0);
        check("reset_no_strobes", nValid + nFerr + nPerr, 0);

        for (int i = 0; i < 7; i++) begin
            v0 = nValid; f0 = nFerr; p0 = nPerr;
            sendFrame(vecs[i].data, 1'b0, vecs[i].stopBit);
            check($sformatf("vec%0d_valid_count", i), nValid - v0, vecs[i].expValid);
            check($sformatf("vec%0d_ferr_count", i), nFerr - f0, vecs[i].expFerr);
            check($sformatf("vec%0d_perr_count", i), nPerr - p0, 0);
            check($sformatf("vec%0d_ovData", i), int'(ovData), int'(vecs[i].expData));
            if (i == 0) begin
                lat = validCyc - startCyc - PAR_EXTRA;
                check("latency_in_154_156", int'(lat >= 154 && lat <= 156), 1);
                if (!(lat >= 154 && lat <= 156)) $display("  latency was %0d cycles", lat);
            end
            if (vecs[i].holdLow > 0) begin
                iRx = 1'b0;
                repeat (vecs[i].holdLow) @(negedge iClk);
                check($sformatf("vec%0d_busy_in_break", i), int'(oBusy), 1);
                check($sformatf("vec%0d_no_restart_in_break", i), nValid + nFerr - v0 - f0, 1);
            end
            if (vecs[i].idleAfter > 0) begin
                idle(vecs[i].idleAfter);
                check($sformatf("vec%0d_busy_after_idle", i), int'(oBusy), 0);
                check($sformatf("vec%0d_ovData_held", i), int'(ovData), int'(vecs[i].expData));
            end
        end

        // 5-cycle low glitch while idle: START check rejects it.
        v0 = nValid; f0 = nFerr;
        iRx = 1'b0;
        repeat (5) @(negedge iClk);
        iRx = 1'b1;
        repeat (2) @(negedge iClk);
        check("glitch_busy_in_start", int'(oBusy), 1);
        idle(30);
        check("glitch_busy_cleared", int'(oBusy), 0);
        check("glitch_no_strobe", nValid + nFerr - v0 - f0, 0);
        check("glitch_ovData_kept", int'(ovData), 8'hFF);

        // Reset in the middle of the data bits of 0x55.
        v0 = nValid; f0 = nFerr;
        iRx = 1'b0;
        repeat (CPB) @(negedge iClk);
        for (int b = 0; b < 3; b++) begin
            iRx = b[0] ? 1'b0 : 1'b1;
            repeat (CPB) @(negedge iClk);
        end
        check("midframe_busy_before_reset", int'(oBusy), 1);
        iReset = 1'b1;
        @(negedge iClk);
        iReset = 1'b0;
        check("midframe_reset_busy", int'(oBusy), 0);
        check("midframe_reset_ovData", int'(ovData), 0);
        idle(200);
        check("midframe_reset_no_strobe", nValid + nFerr - v0 - f0, 0);
        check("midframe_reset_idle_busy", int'(oBusy), 0);
        sendFrame(8'h41, 1'b0, 1'b1);
        check("after_reset_ovData", int'(ovData), 8'h41);
        idle(10);

`ifdef UART_RX_PARITY_EN
        v0 = nValid; p0 = nPerr;
        sendFrame(8'h41, 1'b1, 1'b1);
        check("parity_err_count", nPerr - p0, 1);
        check("parity_no_valid", nValid - v0, 0);
        check("parity_ovData_kept", int'(ovData), 8'h41);
        idle(10);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, limit 2000000 ns");
        $fatal(1);
    end

endmodule
